// File: rtl/screen_text_writer_if.sv
// Command, display-port and screen-memory signals of the screen text writer.
// Handshake: a command transfers on a rising clock edge where cmd_valid && cmd_ready; the source holds cmd_* stable until then.
interface screen_text_writer_if #(
  parameter int SM_LEN       = 11,
  parameter int ALPHABET_LEN = 5
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [1:0]              cmd_op;
  logic [ALPHABET_LEN-1:0] cmd_char;
  logic                    avideo;
  logic [SM_LEN-1:0]       disp_addr;
  logic [SM_LEN-1:0]       mem_addr;
  logic                    mem_we;
  logic [ALPHABET_LEN-1:0] mem_wdata;
  logic [5:0]              cursor_col;
  logic [4:0]              cursor_row;
  logic                    busy;
  logic [1:0]              dbg_state;

  modport master (
    output cmd_valid, cmd_op, cmd_char, avideo, disp_addr,
    input  cmd_ready, mem_addr, mem_we, mem_wdata, cursor_col, cursor_row, busy, dbg_state
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_char, avideo, disp_addr,
    output cmd_ready, mem_addr, mem_we, mem_wdata, cursor_col, cursor_row, busy, dbg_state
  );
endinterface

// File: rtl/screen_text_writer.sv
// Write-side controller for the character screen memory: cursor handling, put/clear
// commands, and sharing of the memory address port with the display driver.
module screen_text_writer #(
  parameter int                      COLS         = 40,
  parameter int                      ROWS         = 30,
  parameter int                      SM_LEN       = 11,
  parameter int                      ALPHABET_LEN = 5,
  parameter logic [ALPHABET_LEN-1:0] BLANK_CODE   = '0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  screen_text_writer_if.slave  bus
);

  localparam logic [SM_LEN-1:0] LAST_ADDR = SM_LEN'(COLS * ROWS - 1);
  localparam logic [5:0]        LAST_COL  = 6'(COLS - 1);
  localparam logic [4:0]        LAST_ROW  = 5'(ROWS - 1);

  localparam logic [1:0] OP_PUT   = 2'b00;
  localparam logic [1:0] OP_NL    = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_HOME  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PUT   = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [5:0]              col_q, col_d;
  logic [4:0]              row_q, row_d;
  logic [SM_LEN-1:0]       cnt_q, cnt_d;
  logic [ALPHABET_LEN-1:0] wdata_q, wdata_d;
  logic                    write_en;
  logic [SM_LEN-1:0]       put_addr;

  assign put_addr = SM_LEN'(row_q) * SM_LEN'(COLS) + SM_LEN'(col_q);

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    wdata_d  = wdata_q;
    write_en = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            OP_PUT: begin
              wdata_d = bus.cmd_char;
              state_d = S_PUT;
            end
            OP_NL: begin
              col_d = '0;
              row_d = (row_q == LAST_ROW) ? '0 : row_q + 5'd1;
            end
            OP_CLEAR: begin
              wdata_d = BLANK_CODE;
              cnt_d   = '0;
              state_d = S_CLEAR;
            end
            OP_HOME: begin
              col_d = '0;
              row_d = '0;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      // Writes only go out while the display is blanked; avideo is used unregistered
      // so a write is withheld in the very cycle active video begins.
      S_PUT: begin
        if (!bus.avideo) begin
          write_en = 1'b1;
          state_d  = S_IDLE;
          if (col_q == LAST_COL) begin
            col_d = '0;
            row_d = (row_q == LAST_ROW) ? '0 : row_q + 5'd1;
          end else begin
            col_d = col_q + 6'd1;
          end
        end
      end
      S_CLEAR: begin
        if (!bus.avideo) begin
          write_en = 1'b1;
          if (cnt_q == LAST_ADDR) begin
            cnt_d   = '0;
            col_d   = '0;
            row_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + SM_LEN'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.cmd_ready  = (state_q == S_IDLE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.mem_we     = write_en;
  assign bus.mem_addr   = write_en ? ((state_q == S_CLEAR) ? cnt_q : put_addr) : bus.disp_addr;
  assign bus.mem_wdata  = wdata_q;
  assign bus.cursor_col = col_q;
  assign bus.cursor_row = row_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_screen_text_writer.sv
// Bench for screen_text_writer: randomized commands against a linear-cursor model
// and a write scoreboard fed by a negedge monitor.
module tb_screen_text_writer;

  localparam int COLS   = 40;
  localparam int ROWS   = 30;
  localparam int CELLS  = COLS * ROWS;
  localparam int SM_LEN = 11;
  localparam int AL     = 5;
  localparam int W      = SM_LEN + AL;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  screen_text_writer_if #(.SM_LEN(SM_LEN), .ALPHABET_LEN(AL)) bus ();

  screen_text_writer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp    = 0;
  int n_err    = 0;
  int pos      = 0;
  int rd_ptr   = 0;
  int viol_cnt = 0;
  int av_mode  = 0;
  int av_ctr   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_log[$];

  // Display-side drivers: avideo mode 0 = low, 1 = high, 2 = random, 3 = 8 high / 8 low.
  initial begin
    bus.avideo    = 1'b0;
    bus.disp_addr = '0;
    forever begin
      @(posedge clock);
      #1;
      bus.disp_addr = SM_LEN'($urandom_range(0, CELLS - 1));
      av_ctr++;
      case (av_mode)
        0:       bus.avideo = 1'b0;
        1:       bus.avideo = 1'b1;
        2:       bus.avideo = 1'($urandom_range(0, 1));
        default: bus.avideo = (((av_ctr / 8) % 2) == 0);
      endcase
    end
  end

  always @(negedge clock) begin
    if (bus.mem_we === 1'b1) begin
      obs_log.push_back({bus.mem_addr, bus.mem_wdata});
      if (bus.avideo !== 1'b0) viol_cnt++;
    end else if (bus.mem_addr !== bus.disp_addr) begin
      viol_cnt++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic void model_accept(input logic [1:0] op, input logic [4:0] ch);
    case (op)
      2'b00: begin
        exp_q.push_back({SM_LEN'(pos), ch});
        pos = (pos + 1) % CELLS;
      end
      2'b01: pos = ((pos / COLS + 1) % ROWS) * COLS;
      2'b10: begin
        for (int a = 0; a < CELLS; a++) exp_q.push_back({SM_LEN'(a), 5'd0});
        pos = 0;
      end
      default: pos = 0;
    endcase
  endfunction

  task automatic send_cmd(input logic [1:0] op, input logic [4:0] ch);
    bit got = 0;
    @(posedge clock);
    #2;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_char  = ch;
    for (int i = 0; i < 5000 && !got; i++) begin
      @(negedge clock);
      if (bus.cmd_ready === 1'b1) got = 1;
    end
    @(posedge clock);
    #2;
    bus.cmd_valid = 1'b0;
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_cmd timeout: cmd_ready stayed 0, required 1");
    end else begin
      model_accept(op, ch);
    end
  endtask

  task automatic wait_idle(input string tag);
    bit got = 0;
    for (int i = 0; i < 5000 && !got; i++) begin
      @(negedge clock);
      if (bus.cmd_ready === 1'b1) got = 1;
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL %s idle timeout: cmd_ready=%b required 1", tag, bus.cmd_ready);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_char  = '0;
    repeat (3) @(negedge clock);
    n_cmp++;
    if ({bus.cmd_ready, bus.busy, bus.mem_we} !== 3'b100) begin
      n_err++;
      $display("FAIL reset_flags: ready/busy/we=%b required 100", {bus.cmd_ready, bus.busy, bus.mem_we});
    end
    n_cmp++;
    if (bus.mem_wdata !== 5'd0) begin
      n_err++;
      $display("FAIL reset_wdata: got %0d required 0", bus.mem_wdata);
    end
    n_cmp++;
    if ({bus.cursor_row, bus.cursor_col} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_cursor: got (%0d,%0d) required (0,0)", bus.cursor_col, bus.cursor_row);
    end
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    pos = 0;
    exp_q.delete();
    rd_ptr = obs_log.size();
  endtask

  task automatic test_put_basic();
    logic [W-1:0] e, g;
    int v0 = viol_cnt;
    av_mode = 0;
    send_cmd(2'b00, 5'd1);
    @(negedge clock);
    n_cmp++;
    if ({bus.mem_we, bus.cmd_ready, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b0, 11'd0, 5'd1}) begin
      n_err++;
      $display("FAIL put_first_cycle: we=%b ready=%b addr=%0d data=%0d required we=1 ready=0 addr=0 data=1",
               bus.mem_we, bus.cmd_ready, bus.mem_addr, bus.mem_wdata);
    end
    @(negedge clock);
    n_cmp++;
    if ({bus.cmd_ready, bus.cursor_row, bus.cursor_col} !== {1'b1, 5'd0, 6'd1}) begin
      n_err++;
      $display("FAIL put_return: ready=%b cursor=(%0d,%0d) required ready=1 cursor=(1,0)",
               bus.cmd_ready, bus.cursor_col, bus.cursor_row);
    end
    #1;
    n_cmp++;
    if (obs_log.size() - rd_ptr != exp_q.size()) begin
      n_err++;
      $display("FAIL put_basic write count: got %0d required %0d", obs_log.size() - rd_ptr, exp_q.size());
    end
    while (exp_q.size() > 0 && rd_ptr < obs_log.size()) begin
      e = exp_q.pop_front();
      g = obs_log[rd_ptr];
      rd_ptr++;
      n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL put_basic write: addr/data %0d/%0d required %0d/%0d", g[W-1:AL], g[AL-1:0], e[W-1:AL], e[AL-1:0]);
      end
    end
    exp_q.delete();
    rd_ptr = obs_log.size();
    n_cmp++;
    if (viol_cnt != v0) begin
      n_err++;
      $display("FAIL put_basic port sharing: %0d violations required 0", viol_cnt - v0);
    end
  endtask

  task automatic test_avideo_wait();
    logic [W-1:0] e, g;
    logic [4:0] ch = 5'($urandom_range(1, 26));
    int v0 = viol_cnt;
    av_mode = 1;
    @(posedge clock);
    #2;
    send_cmd(2'b00, ch);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      n_cmp++;
      if ({bus.mem_we, bus.busy} !== 2'b01) begin
        n_err++;
        $display("FAIL avideo_hold cycle %0d: we=%b busy=%b required we=0 busy=1", i, bus.mem_we, bus.busy);
      end
    end
    av_mode = 0;
    @(negedge clock);
    n_cmp++;
    if (bus.mem_we !== 1'b1) begin
      n_err++;
      $display("FAIL avideo_release: we=%b required 1", bus.mem_we);
    end
    wait_idle("avideo_wait");
    n_cmp++;
    if ({bus.cursor_row, bus.cursor_col} !== {5'(pos / COLS), 6'(pos % COLS)}) begin
      n_err++;
      $display("FAIL avideo_wait cursor: got (%0d,%0d) required (%0d,%0d)", bus.cursor_col, bus.cursor_row, pos % COLS, pos / COLS);
    end
    #1;
    n_cmp++;
    if (obs_log.size() - rd_ptr != exp_q.size()) begin
      n_err++;
      $display("FAIL avideo_wait write count: got %0d required %0d", obs_log.size() - rd_ptr, exp_q.size());
    end
    while (exp_q.size() > 0 && rd_ptr < obs_log.size()) begin
      e = exp_q.pop_front();
      g = obs_log[rd_ptr];
      rd_ptr++;
      n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL avideo_wait write: addr/data %0d/%0d required %0d/%0d", g[W-1:AL], g[AL-1:0], e[W-1:AL], e[AL-1:0]);
      end
    end
    exp_q.delete();
    rd_ptr = obs_log.size();
    n_cmp++;
    if (viol_cnt != v0) begin
      n_err++;
      $display("FAIL avideo_wait port sharing: %0d violations required 0", viol_cnt - v0);
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] e, g;
    int v0 = viol_cnt;
    av_mode = 0;
    send_cmd(2'b11, 5'd0);
    repeat (ROWS - 1) send_cmd(2'b01, 5'd0);
    repeat (COLS - 1) send_cmd(2'b00, 5'($urandom_range(0, 26)));
    wait_idle("wrap_fill");
    n_cmp++;
    if ({bus.cursor_row, bus.cursor_col} !== {5'd29, 6'd39}) begin
      n_err++;
      $display("FAIL wrap_corner cursor: got (%0d,%0d) required (39,29)", bus.cursor_col, bus.cursor_row);
    end
    send_cmd(2'b00, 5'd5);
    wait_idle("wrap_put");
    n_cmp++;
    if ({bus.cursor_row, bus.cursor_col} !== 11'd0) begin
      n_err++;
      $display("FAIL wrap_after_put cursor: got (%0d,%0d) required (0,0)", bus.cursor_col, bus.cursor_row);
    end
    send_cmd(2'b11, 5'd0);
    repeat (ROWS - 1) send_cmd(2'b01, 5'd0);
    repeat (12) send_cmd(2'b00, 5'($urandom_range(0, 26)));
    send_cmd(2'b01, 5'd0);
    wait_idle("wrap_newline");
    n_cmp++;
    if ({bus.cursor_row, bus.cursor_col} !== 11'd0) begin
      n_err++;
      $display("FAIL wrap_newline cursor: got (%0d,%0d) required (0,0)", bus.cursor_col, bus.cursor_row);
    end
    #1;
    n_cmp++;
    if (obs_log.size() - rd_ptr != exp_q.size()) begin
      n_err++;
      $display("FAIL wrap write count: got %0d required %0d", obs_log.size() - rd_ptr, exp_q.size());
    end
    while (exp_q.size() > 0 && rd_ptr < obs_log.size()) begin
      e = exp_q.pop_front();
      g = obs_log[rd_ptr];
      rd_ptr++;
      n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL wrap write: addr/data %0d/%0d required %0d/%0d", g[W-1:AL], g[AL-1:0], e[W-1:AL], e[AL-1:0]);
      end
    end
    exp_q.delete();
    rd_ptr = obs_log.size();
    n_cmp++;
    if (viol_cnt != v0) begin
      n_err++;
      $display("FAIL wrap port sharing: %0d violations required 0", viol_cnt - v0);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] e, g;
    logic [1:0] op;
    int r;
    int v0 = viol_cnt;
    av_mode = 2;
    for (int k = 0; k < 50; k++) begin
      r  = $urandom_range(0, 9);
      op = (r < 6) ? 2'b00 : (r < 9) ? 2'b01 : 2'b11;
      send_cmd(op, 5'($urandom_range(0, 26)));
      wait_idle("random");
      n_cmp++;
      if ({bus.cursor_row, bus.cursor_col} !== {5'(pos / COLS), 6'(pos % COLS)}) begin
        n_err++;
        $display("FAIL random cursor step %0d: got (%0d,%0d) required (%0d,%0d)", k, bus.cursor_col, bus.cursor_row, pos % COLS, pos / COLS);
      end
    end
    #1;
    n_cmp++;
    if (obs_log.size() - rd_ptr != exp_q.size()) begin
      n_err++;
      $display("FAIL random write count: got %0d required %0d", obs_log.size() - rd_ptr, exp_q.size());
    end
    while (exp_q.size() > 0 && rd_ptr < obs_log.size()) begin
      e = exp_q.pop_front();
      g = obs_log[rd_ptr];
      rd_ptr++;
      n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL random write: addr/data %0d/%0d required %0d/%0d", g[W-1:AL], g[AL-1:0], e[W-1:AL], e[AL-1:0]);
      end
    end
    exp_q.delete();
    rd_ptr = obs_log.size();
    n_cmp++;
    if (viol_cnt != v0) begin
      n_err++;
      $display("FAIL random port sharing: %0d violations required 0", viol_cnt - v0);
    end
  endtask

  task automatic test_clear_toggle();
    logic [W-1:0] e, g;
    int v0 = viol_cnt;
    av_mode = 0;
    send_cmd(2'b00, 5'd3);
    av_mode = 3;
    send_cmd(2'b10, 5'd0);
    wait_idle("clear_toggle");
    n_cmp++;
    if ({bus.cursor_row, bus.cursor_col} !== 11'd0) begin
      n_err++;
      $display("FAIL clear cursor: got (%0d,%0d) required (0,0)", bus.cursor_col, bus.cursor_row);
    end
    #1;
    n_cmp++;
    if (obs_log.size() - rd_ptr != exp_q.size()) begin
      n_err++;
      $display("FAIL clear write count: got %0d required %0d", obs_log.size() - rd_ptr, exp_q.size());
    end
    while (exp_q.size() > 0 && rd_ptr < obs_log.size()) begin
      e = exp_q.pop_front();
      g = obs_log[rd_ptr];
      rd_ptr++;
      n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL clear write: addr/data %0d/%0d required %0d/%0d", g[W-1:AL], g[AL-1:0], e[W-1:AL], e[AL-1:0]);
      end
    end
    exp_q.delete();
    rd_ptr = obs_log.size();
    n_cmp++;
    if (viol_cnt != v0) begin
      n_err++;
      $display("FAIL clear port sharing: %0d violations required 0", viol_cnt - v0);
    end
  endtask

  task automatic test_reset_mid_clear();
    logic [W-1:0] e, g;
    int v0 = viol_cnt;
    int seen = 0;
    bit got = 0;
    av_mode = 0;
    send_cmd(2'b00, 5'd7);
    send_cmd(2'b00, 5'd9);
    wait_idle("mid_clear_setup");
    send_cmd(2'b10, 5'd0);
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clock);
      #1;
      if (obs_log.size() - rd_ptr >= 502) got = 1;
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL mid_clear progress: %0d writes required 502", obs_log.size() - rd_ptr);
    end
    #1;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.mem_we, bus.cmd_ready, bus.busy, bus.mem_wdata, bus.cursor_row, bus.cursor_col} !== {1'b0, 1'b1, 1'b0, 5'd0, 11'd0}) begin
      n_err++;
      $display("FAIL mid_clear reset outputs: we=%b ready=%b busy=%b data=%0d cursor=(%0d,%0d) required 0 1 0 0 (0,0)",
               bus.mem_we, bus.cmd_ready, bus.busy, bus.mem_wdata, bus.cursor_col, bus.cursor_row);
    end
    seen = obs_log.size() - rd_ptr;
    n_cmp++;
    if (seen != 502) begin
      n_err++;
      $display("FAIL mid_clear partial count: got %0d required 502", seen);
    end
    while (exp_q.size() > 0 && rd_ptr < obs_log.size()) begin
      e = exp_q.pop_front();
      g = obs_log[rd_ptr];
      rd_ptr++;
      n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL mid_clear partial write: addr/data %0d/%0d required %0d/%0d", g[W-1:AL], g[AL-1:0], e[W-1:AL], e[AL-1:0]);
      end
    end
    exp_q.delete();
    pos = 0;
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    rd_ptr = obs_log.size();
    send_cmd(2'b10, 5'd0);
    wait_idle("mid_clear_restart");
    #1;
    n_cmp++;
    if (obs_log.size() - rd_ptr != exp_q.size()) begin
      n_err++;
      $display("FAIL restart clear write count: got %0d required %0d", obs_log.size() - rd_ptr, exp_q.size());
    end
    while (exp_q.size() > 0 && rd_ptr < obs_log.size()) begin
      e = exp_q.pop_front();
      g = obs_log[rd_ptr];
      rd_ptr++;
      n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL restart clear write: addr/data %0d/%0d required %0d/%0d", g[W-1:AL], g[AL-1:0], e[W-1:AL], e[AL-1:0]);
      end
    end
    exp_q.delete();
    rd_ptr = obs_log.size();
    n_cmp++;
    if (viol_cnt != v0) begin
      n_err++;
      $display("FAIL mid_clear port sharing: %0d violations required 0", viol_cnt - v0);
    end
  endtask

  task automatic test_held_cmd();
    logic [W-1:0] e, g;
    logic [4:0] ch = 5'($urandom_range(1, 26));
    int v0 = viol_cnt;
    bit got = 0;
    av_mode = 0;
    send_cmd(2'b10, 5'd0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b00;
    bus.cmd_char  = ch;
    for (int i = 0; i < 5000 && !got; i++) begin
      @(negedge clock);
      if (bus.cmd_ready === 1'b1) got = 1;
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL held_cmd idle timeout: cmd_ready=%b required 1", bus.cmd_ready);
    end
    n_cmp++;
    if (obs_log.size() - rd_ptr != CELLS) begin
      n_err++;
      $display("FAIL held_cmd writes before accept: got %0d required %0d", obs_log.size() - rd_ptr, CELLS);
    end
    @(posedge clock);
    #2;
    bus.cmd_valid = 1'b0;
    model_accept(2'b00, ch);
    @(negedge clock);
    n_cmp++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 11'd0, ch}) begin
      n_err++;
      $display("FAIL held_cmd put: we=%b addr=%0d data=%0d required we=1 addr=0 data=%0d", bus.mem_we, bus.mem_addr, bus.mem_wdata, ch);
    end
    wait_idle("held_cmd");
    n_cmp++;
    if ({bus.cursor_row, bus.cursor_col} !== {5'd0, 6'd1}) begin
      n_err++;
      $display("FAIL held_cmd cursor: got (%0d,%0d) required (1,0)", bus.cursor_col, bus.cursor_row);
    end
    #1;
    n_cmp++;
    if (obs_log.size() - rd_ptr != exp_q.size()) begin
      n_err++;
      $display("FAIL held_cmd write count: got %0d required %0d", obs_log.size() - rd_ptr, exp_q.size());
    end
    while (exp_q.size() > 0 && rd_ptr < obs_log.size()) begin
      e = exp_q.pop_front();
      g = obs_log[rd_ptr];
      rd_ptr++;
      n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL held_cmd write: addr/data %0d/%0d required %0d/%0d", g[W-1:AL], g[AL-1:0], e[W-1:AL], e[AL-1:0]);
      end
    end
    exp_q.delete();
    rd_ptr = obs_log.size();
    n_cmp++;
    if (viol_cnt != v0) begin
      n_err++;
      $display("FAIL held_cmd port sharing: %0d violations required 0", viol_cnt - v0);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_char  = '0;
    test_reset();
    test_put_basic();
    test_avideo_wait();
    test_wrap();
    test_random();
    test_clear_toggle();
    test_reset_mid_clear();
    test_held_cmd();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
